// File: rtl/pipe_pong_merge.sv
// Two-lane ping-pong merger: recombines alternately split elements into one ordered stream.
// Optional PIPE_PONG_MERGE_COUNT_EN adds a 32-bit dequeue counter port (merge_count).
module pipe_pong_merge #(
  parameter int width = 96,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in0_enq__ENA,
  input  logic [width-1:0] in0_enq_v,
  output logic             in0_enq__RDY,
  input  logic             in1_enq__ENA,
  input  logic [width-1:0] in1_enq_v,
  output logic             in1_enq__RDY,
  input  logic             out_deq__ENA,
  output logic             out_deq__RDY,
  output logic [width-1:0] out_first,
  output logic             out_first__RDY
`ifdef PIPE_PONG_MERGE_COUNT_EN
  ,
  output logic [31:0]      merge_count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [width-1:0] mem [2][DEPTH];
  logic [AW-1:0]    rd_ptr [2];
  logic [AW-1:0]    wr_ptr [2];
  logic [CW-1:0]    count  [2];
  logic             turn;

  logic [1:0]       enq_ena;
  logic [1:0]       enq_rdy;
  logic [1:0]       enq_fire;
  logic [1:0]       deq_lane;
  logic             sel_ready;
  logic             deq_fire;
  logic [width-1:0] enq_data [2];

  assign enq_ena     = {in1_enq__ENA, in0_enq__ENA};
  assign enq_data[0] = in0_enq_v;
  assign enq_data[1] = in1_enq_v;

  // Handshake decode; readiness is a function of registered counts only.
  always_comb begin
    enq_rdy[0] = (count[0] != CW'(DEPTH));
    enq_rdy[1] = (count[1] != CW'(DEPTH));
    enq_fire   = enq_ena & enq_rdy;
    sel_ready  = (count[turn] != CW'(0));
    deq_fire   = out_deq__ENA && sel_ready;
    if (!deq_fire) begin
      deq_lane = 2'b00;
    end else if (turn) begin
      deq_lane = 2'b10;
    end else begin
      deq_lane = 2'b01;
    end
  end

  assign in0_enq__RDY   = enq_rdy[0];
  assign in1_enq__RDY   = enq_rdy[1];
  assign out_deq__RDY   = sel_ready;
  assign out_first__RDY = sel_ready;
  assign out_first      = sel_ready ? mem[turn][rd_ptr[turn]] : '0;

  // Lane storage; contents are don't-care after reset so no reset is applied.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (enq_fire[k]) begin
        mem[k][wr_ptr[k]] <= enq_data[k];
      end
    end
  end

  // Pointer, occupancy and turn state; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < 2; k++) begin
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
        count[k]  <= '0;
      end
      turn <= 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (enq_fire[k]) begin
          wr_ptr[k] <= wr_ptr[k] + AW'(1);
        end
        if (deq_lane[k]) begin
          rd_ptr[k] <= rd_ptr[k] + AW'(1);
        end
        count[k] <= count[k] + CW'(enq_fire[k]) - CW'(deq_lane[k]);
      end
      if (deq_fire) begin
        turn <= ~turn;
      end
    end
  end

`ifdef PIPE_PONG_MERGE_COUNT_EN
  // Dequeue counter, wraps at 2^32.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      merge_count <= 32'd0;
    end else if (deq_fire) begin
      merge_count <= merge_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_pong_merge.sv
// Directed self-checking bench for pipe_pong_merge (DEPTH=2, width=96).
module tb_pipe_pong_merge;

  localparam int W = 96;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         in0_enq__ENA = 1'b0;
  logic [W-1:0] in0_enq_v = '0;
  logic         in0_enq__RDY;
  logic         in1_enq__ENA = 1'b0;
  logic [W-1:0] in1_enq_v = '0;
  logic         in1_enq__RDY;
  logic         out_deq__ENA = 1'b0;
  logic         out_deq__RDY;
  logic [W-1:0] out_first;
  logic         out_first__RDY;
`ifdef PIPE_PONG_MERGE_COUNT_EN
  logic [31:0]  merge_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  pipe_pong_merge #(.width(W), .DEPTH(2)) dut (
    .CLK(CLK), .RST(RST),
    .in0_enq__ENA(in0_enq__ENA), .in0_enq_v(in0_enq_v), .in0_enq__RDY(in0_enq__RDY),
    .in1_enq__ENA(in1_enq__ENA), .in1_enq_v(in1_enq_v), .in1_enq__RDY(in1_enq__RDY),
    .out_deq__ENA(out_deq__ENA), .out_deq__RDY(out_deq__RDY),
    .out_first(out_first), .out_first__RDY(out_first__RDY)
`ifdef PIPE_PONG_MERGE_COUNT_EN
    , .merge_count(merge_count)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] elem(input int lane, input int i);
    return {8'(lane), 24'(i), 64'h0123_4567_89AB_CDEF};
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    in0_enq__ENA = 1'b0;
    in1_enq__ENA = 1'b0;
    out_deq__ENA = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    RST = 1'b1;
    cyc();
    cyc();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (in0_enq__RDY !== 1'b1 || in1_enq__RDY !== 1'b1 || out_deq__RDY !== 1'b0 ||
        out_first__RDY !== 1'b0 || out_first !== '0) begin
      n_err++;
      $display("FAIL reset: rdy0=%b rdy1=%b deq=%b frdy=%b first=%h required 1 1 0 0 0",
               in0_enq__RDY, in1_enq__RDY, out_deq__RDY, out_first__RDY, out_first);
    end
  endtask

  task automatic test_single();
    apply_reset();
    in0_enq__ENA = 1'b1; in0_enq_v = elem(0, 7);
    cyc();
    idle();
    n_cmp++;
    if (out_first !== elem(0, 7) || out_first__RDY !== 1'b1) begin
      n_err++;
      $display("FAIL single_latency: first=%h rdy=%b required %h 1", out_first, out_first__RDY, elem(0, 7));
    end
    out_deq__ENA = 1'b1;
    cyc();
    idle();
    n_cmp++;
    if (out_first__RDY !== 1'b0 || out_deq__RDY !== 1'b0 || out_first !== '0) begin
      n_err++;
      $display("FAIL single_turn: frdy=%b deq=%b first=%h required 0 0 0", out_first__RDY, out_deq__RDY, out_first);
    end
  endtask

  task automatic test_skew();
    apply_reset();
    in1_enq__ENA = 1'b1; in1_enq_v = elem(1, 0);
    cyc();
    in1_enq_v = elem(1, 1);
    cyc();
    idle();
    n_cmp++;
    if (in1_enq__RDY !== 1'b0 || out_first__RDY !== 1'b0) begin
      n_err++;
      $display("FAIL skew_hold: rdy1=%b frdy=%b required 0 0", in1_enq__RDY, out_first__RDY);
    end
    in0_enq__ENA = 1'b1; in0_enq_v = elem(0, 0);
    cyc();
    idle();
    n_cmp++;
    if (out_first !== elem(0, 0) || out_first__RDY !== 1'b1) begin
      n_err++;
      $display("FAIL skew_a0: first=%h rdy=%b required %h 1", out_first, out_first__RDY, elem(0, 0));
    end
    out_deq__ENA = 1'b1;
    cyc();
    n_cmp++;
    if (out_first !== elem(1, 0) || out_first__RDY !== 1'b1) begin
      n_err++;
      $display("FAIL skew_b0: first=%h rdy=%b required %h 1", out_first, out_first__RDY, elem(1, 0));
    end
    cyc();
    idle();
    n_cmp++;
    if (out_first__RDY !== 1'b0 || in1_enq__RDY !== 1'b1) begin
      n_err++;
      $display("FAIL skew_stall: frdy=%b rdy1=%b required 0 1", out_first__RDY, in1_enq__RDY);
    end
    in0_enq__ENA = 1'b1; in0_enq_v = elem(0, 1);
    cyc();
    idle();
    n_cmp++;
    if (out_first !== elem(0, 1) || out_first__RDY !== 1'b1) begin
      n_err++;
      $display("FAIL skew_a1: first=%h rdy=%b required %h 1", out_first, out_first__RDY, elem(0, 1));
    end
    out_deq__ENA = 1'b1;
    cyc();
    n_cmp++;
    if (out_first !== elem(1, 1) || out_first__RDY !== 1'b1) begin
      n_err++;
      $display("FAIL skew_b1: first=%h rdy=%b required %h 1", out_first, out_first__RDY, elem(1, 1));
    end
    cyc();
    idle();
    n_cmp++;
    if (out_first__RDY !== 1'b0) begin
      n_err++;
      $display("FAIL skew_empty: frdy=%b required 0", out_first__RDY);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    apply_reset();
    for (int k = 0; k <= 64; k++) begin
      if (k >= 1) begin
        exp = elem((k - 1) % 2, (k - 1) / 2);
        n_cmp++;
        if (out_first !== exp || out_first__RDY !== 1'b1 || in0_enq__RDY !== 1'b1 || in1_enq__RDY !== 1'b1) begin
          n_err++;
          $display("FAIL b2b[%0d]: first=%h frdy=%b rdy0=%b rdy1=%b required %h 1 1 1",
                   k - 1, out_first, out_first__RDY, in0_enq__RDY, in1_enq__RDY, exp);
        end
      end
      in0_enq__ENA = (k < 64) && (k % 2 == 0);
      in0_enq_v    = elem(0, k / 2);
      in1_enq__ENA = (k < 64) && (k % 2 == 1);
      in1_enq_v    = elem(1, k / 2);
      out_deq__ENA = 1'b1;
      cyc();
    end
    idle();
    n_cmp++;
    if (out_first__RDY !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain: frdy=%b required 0", out_first__RDY);
    end
  endtask

  task automatic test_full_no_bypass();
    apply_reset();
    in0_enq__ENA = 1'b1; in0_enq_v = elem(0, 0);
    cyc();
    in0_enq_v = elem(0, 1);
    cyc();
    idle();
    n_cmp++;
    if (in0_enq__RDY !== 1'b0) begin
      n_err++;
      $display("FAIL full_rdy: rdy0=%b required 0", in0_enq__RDY);
    end
    in0_enq__ENA = 1'b1; in0_enq_v = elem(0, 2);
    out_deq__ENA = 1'b1;
    cyc();
    idle();
    n_cmp++;
    if (in0_enq__RDY !== 1'b1 || out_first__RDY !== 1'b0) begin
      n_err++;
      $display("FAIL full_deq: rdy0=%b frdy=%b required 1 0", in0_enq__RDY, out_first__RDY);
    end
    in1_enq__ENA = 1'b1; in1_enq_v = elem(1, 0);
    cyc();
    idle();
    out_deq__ENA = 1'b1;
    cyc();
    n_cmp++;
    if (out_first !== elem(0, 1) || out_first__RDY !== 1'b1) begin
      n_err++;
      $display("FAIL full_next: first=%h rdy=%b required %h 1", out_first, out_first__RDY, elem(0, 1));
    end
    cyc();
    idle();
    in1_enq__ENA = 1'b1; in1_enq_v = elem(1, 1);
    cyc();
    idle();
    out_deq__ENA = 1'b1;
    cyc();
    idle();
    n_cmp++;
    if (out_first__RDY !== 1'b0 || in0_enq__RDY !== 1'b1) begin
      n_err++;
      $display("FAIL full_rejected: frdy=%b rdy0=%b required 0 1", out_first__RDY, in0_enq__RDY);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    in0_enq__ENA = 1'b1; in0_enq_v = elem(0, 0);
    in1_enq__ENA = 1'b1; in1_enq_v = elem(1, 0);
    cyc();
    in1_enq__ENA = 1'b0; in0_enq_v = elem(0, 1);
    cyc();
    idle();
    n_cmp++;
    if (in0_enq__RDY !== 1'b0 || out_first__RDY !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset: rdy0=%b frdy=%b required 0 1", in0_enq__RDY, out_first__RDY);
    end
    #2;
    RST = 1'b1;
    #1;
    n_cmp++;
    if (in0_enq__RDY !== 1'b1 || in1_enq__RDY !== 1'b1 || out_deq__RDY !== 1'b0 ||
        out_first__RDY !== 1'b0 || out_first !== '0) begin
      n_err++;
      $display("FAIL async_reset: rdy0=%b rdy1=%b deq=%b frdy=%b first=%h required 1 1 0 0 0",
               in0_enq__RDY, in1_enq__RDY, out_deq__RDY, out_first__RDY, out_first);
    end
    #1;
    RST = 1'b0;
    in1_enq__ENA = 1'b1; in1_enq_v = elem(1, 9);
    cyc();
    idle();
    n_cmp++;
    if (out_first__RDY !== 1'b0 || out_first !== '0) begin
      n_err++;
      $display("FAIL post_reset_l1: frdy=%b first=%h required 0 0", out_first__RDY, out_first);
    end
    in0_enq__ENA = 1'b1; in0_enq_v = elem(0, 9);
    cyc();
    idle();
    n_cmp++;
    if (out_first !== elem(0, 9) || out_first__RDY !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_l0: first=%h rdy=%b required %h 1", out_first, out_first__RDY, elem(0, 9));
    end
    out_deq__ENA = 1'b1;
    cyc();
    idle();
    n_cmp++;
    if (out_first !== elem(1, 9) || out_first__RDY !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_order: first=%h rdy=%b required %h 1", out_first, out_first__RDY, elem(1, 9));
    end
  endtask

`ifdef PIPE_PONG_MERGE_COUNT_EN
  task automatic test_count();
    apply_reset();
    for (int k = 0; k <= 10; k++) begin
      in0_enq__ENA = (k < 10) && (k % 2 == 0);
      in0_enq_v    = elem(0, k);
      in1_enq__ENA = (k < 10) && (k % 2 == 1);
      in1_enq_v    = elem(1, k);
      out_deq__ENA = 1'b1;
      cyc();
    end
    idle();
    n_cmp++;
    if (merge_count !== 32'd10) begin
      n_err++;
      $display("FAIL count_10: merge_count=%0d required 10", merge_count);
    end
    force dut.merge_count = 32'hFFFF_FFFF;
    #1;
    release dut.merge_count;
    in0_enq__ENA = 1'b1; in0_enq_v = elem(0, 3);
    cyc();
    idle();
    out_deq__ENA = 1'b1;
    cyc();
    idle();
    n_cmp++;
    if (merge_count !== 32'd0) begin
      n_err++;
      $display("FAIL count_wrap: merge_count=%h required 0", merge_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_skew();
    test_back_to_back();
    test_full_no_bypass();
    test_async_reset();
`ifdef PIPE_PONG_MERGE_COUNT_EN
    test_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
